// File: rtl/score_display_pkg.sv
// Shared types and helpers for the score display path.
//   - widths and display limits
//   - converter FSM state type
//   - score clamp and 7-segment lookup (active-high, gfedcba)
package score_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = 14;
  localparam int BCD_W      = 16;
  localparam logic [SCORE_W-1:0] MAX_DISPLAY = 14'd9999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
    return (s > MAX_DISPLAY) ? MAX_DISPLAY : s;
  endfunction

  // Nibbles above 9 never occur from the converter, but map to blank anyway.
  function automatic logic [6:0] seg_lut(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   i_Start        : request a conversion of i_Bin (accepted only in IDLE)
//   i_Bin          : raw binary score, clamped to 9999 on latch
//   o_Busy         : converter is in SHIFT or DONE
//   o_Done         : high for the single DONE cycle; o_Bcd/o_Val are final then
//   o_Bcd          : BCD shift register (intermediate until o_Done)
//   o_Val          : clamped binary value that is being / was converted
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Start,
  input  logic [SCORE_W-1:0] i_Bin,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [BCD_W-1:0]   o_Bcd,
  output logic [SCORE_W-1:0] o_Val
);

  conv_state_e        state_q;
  logic [SCORE_W-1:0] bin_q;
  logic [SCORE_W-1:0] val_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         cnt_q;

  // Add-3 correction on every nibble that would overflow past 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd_q[d*4 +: 4] >= 4'd5)
        bcd_adj[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      val_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_Start) begin
          val_q   <= clamp_score(i_Bin);
          bin_q   <= clamp_score(i_Bin);
          bcd_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
          bin_q <= {bin_q[SCORE_W-2:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(SCORE_W - 1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Busy = (state_q != IDLE);
  assign o_Done = (state_q == DONE);
  assign o_Bcd  = bcd_q;
  assign o_Val  = val_q;

endmodule

// File: rtl/score_display_driver.sv
// Score display driver: binary score -> BCD -> multiplexed 4-digit 7-segment.
//   i_Clk, i_Rst_n : clock, async active-low reset
//   i_Score        : binary score (values above 9999 shown as 9999)
//   o_Bcd          : registered {thousands,hundreds,tens,ones}
//   o_BcdValid     : one-cycle pulse when o_Bcd updates
//   o_Seg          : segments {g,f,e,d,c,b,a}, active-low when COMMON_ANODE
//   o_Dp           : decimal point, held inactive
//   o_Digit        : digit enables, bit0 = ones, active-low when COMMON_ANODE
module score_display_driver
  import score_display_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int COMMON_ANODE  = 1,
  parameter int BLANK_LEADING = 1
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic [SCORE_W-1:0] i_Score,
  output logic [BCD_W-1:0]   o_Bcd,
  output logic               o_BcdValid,
  output logic [6:0]         o_Seg,
  output logic               o_Dp,
  output logic [NUM_DIGITS-1:0] o_Digit
);

  localparam int   PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic INV = (COMMON_ANODE != 0);

  // ---------------- conversion ----------------
  logic [SCORE_W-1:0] last_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               valid_q;
  logic               conv_start, conv_busy, conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic [SCORE_W-1:0] conv_val;

  // Converter only looks at start while idle, so changes mid-conversion are
  // picked up on the first idle cycle afterwards.
  assign conv_start = (clamp_score(i_Score) != last_q);

  bin2bcd_seq u_conv (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Start (conv_start),
    .i_Bin   (i_Score),
    .o_Busy  (conv_busy),
    .o_Done  (conv_done),
    .o_Bcd   (conv_bcd),
    .o_Val   (conv_val)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bcd_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= conv_done;
      if (conv_done) begin
        bcd_q  <= conv_bcd;
        last_q <= conv_val;
      end
    end
  end

  // ---------------- scan ----------------
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // ---------------- blanking + LUT ----------------
  logic [BCD_W-1:0]      upper;
  logic                  blank;
  logic [6:0]            seg_d, seg_q;
  logic [NUM_DIGITS-1:0] dig_d, dig_q;

  // upper holds the current digit and everything above it; the digit is a
  // leading zero when that whole span is zero. Ones (idx 0) always shows.
  always_comb begin
    upper = bcd_q >> {idx_q, 2'b00};
    blank = (BLANK_LEADING != 0) && (idx_q != 2'd0) && (upper == '0);
    seg_d = blank ? 7'b0000000 : seg_lut(upper[3:0]);
    if (INV) seg_d = ~seg_d;
    dig_d = NUM_DIGITS'(1) << idx_q;
    if (INV) dig_d = ~dig_d;
  end

  // Segments and enables register together so no digit sees another's pattern.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      seg_q <= {7{INV}};
      dig_q <= {NUM_DIGITS{INV}};
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign o_Bcd      = bcd_q;
  assign o_BcdValid = valid_q;
  assign o_Seg      = seg_q;
  assign o_Dp       = INV;
  assign o_Digit    = dig_q;

endmodule

// File: tb/tb_score_display_driver.sv
module tb_score_display_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score1 = '0, score2 = 14'd7;

  logic [15:0] bcd1, bcd2;
  logic        v1, v2, dp1, dp2;
  logic [6:0]  seg1, seg2;
  logic [3:0]  dig1, dig2;

  always #5 clk = ~clk;

  score_display_driver #(.SCAN_DIV(4), .COMMON_ANODE(1), .BLANK_LEADING(1)) dut1 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Score(score1),
    .o_Bcd(bcd1), .o_BcdValid(v1), .o_Seg(seg1), .o_Dp(dp1), .o_Digit(dig1));

  score_display_driver #(.SCAN_DIV(4), .COMMON_ANODE(0), .BLANK_LEADING(0)) dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Score(score2),
    .o_Bcd(bcd2), .o_BcdValid(v2), .o_Seg(seg2), .o_Dp(dp2), .o_Digit(dig2));

  int n_run = 0, n_fail = 0;

  task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [6:0] cap1 [4];
  logic [6:0] cap2 [4];
  int bad1, bad2, dpbad;

  // Record the segment pattern shown on each digit over a full scan.
  task automatic scan_capture();
    for (int d = 0; d < 4; d++) begin cap1[d] = 'x; cap2[d] = 'x; end
    bad1 = 0; bad2 = 0; dpbad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      case (dig1)
        4'b1110: cap1[0] = seg1;
        4'b1101: cap1[1] = seg1;
        4'b1011: cap1[2] = seg1;
        4'b0111: cap1[3] = seg1;
        default: bad1++;
      endcase
      case (dig2)
        4'b0001: cap2[0] = seg2;
        4'b0010: cap2[1] = seg2;
        4'b0100: cap2[2] = seg2;
        4'b1000: cap2[3] = seg2;
        default: bad2++;
      endcase
      if (dp2 !== 1'b0 || dp1 !== 1'b1) dpbad++;
    end
  endtask

  task automatic wait_valid(input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!v1 && cyc < lim);
    ck("valid_seen", v1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int c, c2;
    logic vseen;
    logic [3:0] e;

    // reset state
    repeat (3) @(negedge clk);
    ck("rst_bcd", bcd1, 0);
    ck("rst_valid", v1, 0);
    ck("rst_seg", seg1, 7'h7F);
    ck("rst_dig", dig1, 4'hF);
    ck("rst_dig_ch", dig2, 4'h0);
    ck("rst_seg_ch", seg2, 7'h00);

    // scan order with score 0, no conversion pulse
    rst_n = 1'b1;
    vseen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = ~(4'b0001 << (i / 4));
      ck("scan_order", dig1, e);
      vseen |= v1;
    end
    scan_capture();
    vseen |= v1;
    ck("zero_no_valid", vseen, 0);
    ck("zero_onehot", bad1, 0);
    ck("zero_d0", cap1[0], 7'b1000000);
    ck("zero_d1", cap1[1], 7'b1111111);
    ck("zero_d2", cap1[2], 7'b1111111);
    ck("zero_d3", cap1[3], 7'b1111111);

    // 1234: valid exactly 15 edges after the sampling edge
    score1 = 14'd1234;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      ck($sformatf("lat_k%0d", k), v1, (k == 15));
    end
    ck("bcd_1234", bcd1, 16'h1234);
    scan_capture();
    ck("d3_1", cap1[3], 7'b1111001);
    ck("d2_2", cap1[2], 7'b0100100);
    ck("d1_3", cap1[1], 7'b0110000);
    ck("d0_4", cap1[0], 7'b0011001);

    // saturation
    score1 = 14'd16383;
    wait_valid(40, c);
    ck("bcd_sat", bcd1, 16'h9999);
    scan_capture();
    for (int d = 0; d < 4; d++) ck($sformatf("sat_d%0d", d), cap1[d], 7'b0010000);

    // change during SHIFT: 5 then 10
    score1 = 14'd5;
    repeat (4) @(negedge clk);
    score1 = 14'd10;
    wait_valid(40, c);
    ck("bcd_first", bcd1, 16'h0005);
    c2 = 0;
    do begin @(negedge clk); c2++; end while (!v1 && c2 < 40);
    ck("gap", c2, 16);
    ck("bcd_second", bcd1, 16'h0010);
    scan_capture();
    ck("ten_d3", cap1[3], 7'b1111111);
    ck("ten_d2", cap1[2], 7'b1111111);
    ck("ten_d1", cap1[1], 7'b1111001);
    ck("ten_d0", cap1[0], 7'b1000000);

    // asynchronous reset mid-SHIFT
    score1 = 14'd1234;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    ck("arst_bcd", bcd1, 0);
    ck("arst_valid", v1, 0);
    ck("arst_seg", seg1, 7'h7F);
    ck("arst_dig", dig1, 4'hF);
    @(negedge clk);
    score1 = 14'd9999;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(16, c);
    ck("arst_bcd9999", bcd1, 16'h9999);

    // common cathode, no blanking, score 7
    scan_capture();
    ck("cc_onehot", bad2, 0);
    ck("cc_d3", cap2[3], 7'b0111111);
    ck("cc_d2", cap2[2], 7'b0111111);
    ck("cc_d1", cap2[1], 7'b0111111);
    ck("cc_d0", cap2[0], 7'b0000111);
    ck("cc_bcd", bcd2, 16'h0007);
    ck("dp_levels", dpbad, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
Downstream consumer of the 14-bit saturating score counter. Converts the binary score to 4-digit BCD with a sequential double-dabble engine, then time-multiplexes the digits onto a 4-digit 7-segment display with leading-zero blanking. The BCD result is also exported for other display consumers, such as a VGA score overlay.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled (legal range 2..2^20)
COMMON_ANODE, 1, 1 = segment and digit outputs active-low; 0 = active-high
BLANK_LEADING, 1, 1 = blank leading zero digits; 0 = show all four digits

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  reset
i_Score  in  14  binary score, 0..9999 nominal
o_Bcd  out  16  {thousands, hundreds, tens, ones}, registered
o_BcdValid  out  1  one-cycle pulse when o_Bcd updates
o_Seg  out  7  segments {g,f,e,d,c,b,a}, polarity per COMMON_ANODE
o_Dp  out  1  decimal point, always inactive level
o_Digit  out  4  digit enables, bit0 = ones (rightmost), polarity per COMMON_ANODE

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port i_Clk, reset port i_Rst_n.
- Reset values:
  - o_Bcd=0, o_BcdValid=0.
  - Internal last-converted value=0; score 0 therefore needs no conversion after reset.
  - Scan index=0, prescaler=0.
  - o_Seg, o_Dp, o_Digit at inactive level.
  - FSM=IDLE.
- Clamp: if i_Score > 9999, the converted value is 9999.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: if the clamped i_Score differs from last-converted, latch it, clear the BCD shift register and bit counter, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: one bit per cycle. First add 3 to every BCD nibble >= 5, then shift left by one, pulling in the binary MSB. After 14 SHIFT cycles, go to DONE.
  - DONE: write o_Bcd, update last-converted, pulse o_BcdValid, go to IDLE.
  - Latency: change sampled at cycle N -> o_Bcd/o_BcdValid at cycle N+15 (1 IDLE + 14 SHIFT); new value visible N+16.
  - i_Score changes during SHIFT/DONE are ignored. IDLE re-samples the latest value on the next cycle, so the final value is always converted.
  - o_Bcd never shows intermediate shift-register contents.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 continuously.
  - On wrap, the digit index advances 0->1->2->3->0.
  - Exactly one digit is enabled at any time after reset release.
- Blanking (BLANK_LEADING=1):
  - A digit is blanked (all segments inactive, its enable still driven) if it and every higher digit are 0.
  - The ones digit is never blanked.
- Segment LUT (active-high, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Nibbles >9 map to blank.
  - COMMON_ANODE inverts the LUT output.
- o_Seg/o_Digit are registered and change together, one cycle after the index update, so there is no ghosting.
- Reset mid-conversion: the FSM aborts to IDLE and outputs return to reset values. After release, conversion restarts if i_Score != 0.

Decomposition:
- Package score_display_pkg:
  - NUM_DIGITS=4, MAX_DISPLAY=14'd9999, SCORE_W=14, BCD_W=16
  - converter state typedef {IDLE, SHIFT, DONE}
  - seven-segment LUT function
- Sub-module bin2bcd_seq: clamp, FSM and double-dabble datapath, with start/busy/done handshake.
- Top level: change detect, scan prescaler, blanking and LUT.

Test Plan:
- Reset, i_Score=0, COMMON_ANODE=1, SCAN_DIV=4 -> no o_BcdValid. o_Digit cycles 1110,1101,1011,0111 every 4 clocks. Ones digit shows 1000000 ("0"); the other three digits show 1111111 (blanked).
- Step i_Score 0->1234 at cycle N -> o_BcdValid high only at N+15. o_Bcd=16'h1234, and all four digits are displayed.
- i_Score=14'd16383 -> o_Bcd=16'h9999. Each digit shows 0010000 ("9", active-low).
- i_Score 5->10 during SHIFT of the 5 conversion -> first pulse gives o_Bcd=16'h0005, second pulse 16 cycles later gives 16'h0010. Thousands and hundreds are blanked; the tens digit shows "1".
- Deassert i_Rst_n mid-SHIFT -> outputs inactive and o_Bcd=0 immediately (asynchronous). After release with i_Score=9999, o_Bcd=16'h9999 within 16 cycles.
- BLANK_LEADING=0, COMMON_ANODE=0, i_Score=7 -> digits show 0111111,0111111,0111111,0000111 (thousands to ones). o_Dp=0 throughout.
